// File: rtl/aes_pkg.sv
// Shared AES definitions for the streaming wrapper and its core.
//   - block width, core latency and the ECB/CTR mode encoding
//   - FIPS-197 / SP800-38A known-answer vectors for benches
//   - byte-level AES round helpers used by the pipelined core
package aes_pkg;

    localparam int AES_BLK_W        = 128;
    localparam int AES_CORE_LATENCY = 20;

    typedef enum logic {
        AES_ECB = 1'b0,
        AES_CTR = 1'b1
    } aes_mode_e;

    localparam logic [127:0] FIPS_KEY_A  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT_A   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT_A   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] FIPS_KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] FIPS_CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] SP_CTR_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] SP_CTR_INIT = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
    localparam logic [127:0] SP_CTR_PT1  = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] SP_CTR_CT1  = 128'h874d6191b620e3261bef6864990db6ce;
    localparam logic [127:0] SP_CTR_PT2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] SP_CTR_CT2  = 128'h9806f66b7970fdff8617187bb9fffdff;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Inverse computed as b^254 (square-and-multiply), then the affine map.
    function automatic logic [7:0] aes_sbox(input logic [7:0] b);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = b;
        inv = 8'h01;
        for (int unsigned i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int unsigned i = 0; i < 16; i++) o[8*i +: 8] = aes_sbox(s[8*i +: 8]);
        return o;
    endfunction

    // Byte i sits at bits [127-8i -: 8]; row = i%4, column = i/4.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int unsigned c = 0; c < 4; c++)
            for (int unsigned r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        for (int unsigned c = 0; c < 4; c++) begin
            {a0, a1, a2, a3} = s[127-32*c -: 32];
            o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                 a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                 a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                 xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
        return o;
    endfunction

    function automatic logic [7:0] rcon(input int unsigned round);
        logic [7:0] rc;
        rc = 8'h01;
        for (int unsigned i = 0; i < round; i++) rc = xtime(rc);
        return rc;
    endfunction

    function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        {w0, w1, w2, w3} = k;
        t  = {aes_sbox(w3[23:16]), aes_sbox(w3[15:8]), aes_sbox(w3[7:0]), aes_sbox(w3[31:24])}
             ^ {rc, 24'h000000};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

endpackage

// File: rtl/aes_128.sv
// Fixed-latency pipelined AES-128 encryption core, one block per cycle.
// Two register stages per round (SubBytes/ShiftRows + key step, then
// MixColumns/AddRoundKey), so latency is AES_CORE_LATENCY = 20 cycles.
// Datapath registers are not reset.
//   clk   : clock, rising edge
//   state : plaintext block
//   key   : cipher key, travels with its block
//   out   : ciphertext, valid 20 cycles after state/key are presented
module aes_128
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic [127:0] state,
    input  logic [127:0] key,
    output logic [127:0] out
);

    for (genvar r = 0; r < 10; r++) begin : g_round
        logic [127:0] s_in, k_in, sa, ka, sb;

        if (r == 0) begin : g_first
            assign s_in = state ^ key;
            assign k_in = key;
        end else begin : g_next
            assign s_in = g_round[r-1].sb;
            assign k_in = g_round[r-1].g_kpipe.kb;
        end

        always_ff @(posedge clk) begin
            sa <= shift_rows(sub_bytes(s_in));
            ka <= key_step(k_in, rcon(r));
            sb <= ((r == 9) ? sa : mix_columns(sa)) ^ ka;
        end

        // The final round key is consumed in its own round only.
        if (r < 9) begin : g_kpipe
            logic [127:0] kb;
            always_ff @(posedge clk) kb <= ka;
        end
    end

    assign out = g_round[9].sb;

endmodule

// File: rtl/aes_stream_fifo.sv
// Synchronous FIFO with pointer-based full/empty, no fall-through.
//   clk, rst : clock, async active-high reset (empties the FIFO)
//   wr_en, wr_data : push (ignored when full; a push into full is an error)
//   rd_en, rd_data : pop (ignored when empty); rd_data shows the head
//   empty          : no entries
module aes_stream_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr, rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             full;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en && !full) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !full) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    assign rd_data = mem[rd_ptr[AW-1:0]];

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(wr_en && full));

endmodule

// File: rtl/aes_128_stream.sv
// Streaming valid/ready wrapper around the pipelined aes_128 core with
// per-beat ECB/CTR mode, tags, an internal CTR counter and a credit-managed
// output FIFO that absorbs everything the non-stallable core has in flight.
//   clk, rst              : clock, async active-high reset
//   ctr_load, ctr_init    : load the counter (blocks input that cycle)
//   in_valid/in_ready     : input handshake; in_mode 0=ECB 1=CTR
//   in_data, in_key, in_tag : plaintext, key, sideband tag
//   out_valid/out_ready   : output handshake
//   out_data, out_tag     : ciphertext and its tag (zero when no output)
module aes_128_stream
    import aes_pkg::*;
#(
    parameter int CORE_LATENCY = 20,
    parameter int TAG_W        = 4,
    parameter int DEPTH        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ctr_load,
    input  logic [127:0]     ctr_init,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [127:0]     in_data,
    input  logic [127:0]     in_key,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_data,
    output logic [TAG_W-1:0] out_tag
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int LT = CORE_LATENCY - 1;

    aes_mode_e          mode_in;
    logic               accept, out_fire, fifo_empty;
    logic [CW-1:0]      credit;
    logic [127:0]       ctr, core_in, core_out;
    logic [TAG_W+127:0] fifo_wdata, fifo_rdata;

    // Sideband delay line, aligned with the core pipeline.
    logic               dl_valid [CORE_LATENCY];
    aes_mode_e          dl_mode  [CORE_LATENCY];
    logic [TAG_W-1:0]   dl_tag   [CORE_LATENCY];
    logic [127:0]       dl_data  [CORE_LATENCY];

    assign mode_in  = aes_mode_e'(in_mode);
    // Credits cover in-flight plus FIFO-resident beats, so the FIFO never overflows.
    assign in_ready = !rst && !ctr_load && (credit < CW'(DEPTH));
    assign accept   = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign core_in  = (mode_in == AES_CTR) ? ctr : in_data;

    aes_128 u_core (
        .clk   (clk),
        .state (core_in),
        .key   (in_key),
        .out   (core_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < CORE_LATENCY; i++) begin
                dl_valid[i] <= 1'b0;
                dl_mode[i]  <= AES_ECB;
                dl_tag[i]   <= '0;
                dl_data[i]  <= '0;
            end
        end else begin
            dl_valid[0] <= accept;
            dl_mode[0]  <= mode_in;
            dl_tag[0]   <= in_tag;
            dl_data[0]  <= in_data;
            for (int unsigned i = 1; i < CORE_LATENCY; i++) begin
                dl_valid[i] <= dl_valid[i-1];
                dl_mode[i]  <= dl_mode[i-1];
                dl_tag[i]   <= dl_tag[i-1];
                dl_data[i]  <= dl_data[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctr    <= '0;
            credit <= '0;
        end else begin
            if (ctr_load)
                ctr <= ctr_init;
            else if (accept && mode_in == AES_CTR)
                ctr[31:0] <= ctr[31:0] + 32'd1;

            if (accept && !out_fire)
                credit <= credit + 1'b1;
            else if (!accept && out_fire)
                credit <= credit - 1'b1;
        end
    end

    assign fifo_wdata = {dl_tag[LT],
                         (dl_mode[LT] == AES_CTR) ? (core_out ^ dl_data[LT]) : core_out};

    aes_stream_fifo #(
        .WIDTH (TAG_W + 128),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (dl_valid[LT]),
        .wr_data (fifo_wdata),
        .rd_en   (out_ready),
        .rd_data (fifo_rdata),
        .empty   (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign out_data  = fifo_empty ? '0 : fifo_rdata[127:0];
    assign out_tag   = fifo_empty ? '0 : fifo_rdata[TAG_W+127:128];

endmodule

// File: tb/tb_aes_128_stream.sv
module tb_aes_128_stream;
    import aes_pkg::*;

    localparam int L  = 20;
    localparam int TW = 4;
    localparam int D  = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ctr_load = 1'b0;
    logic [127:0]  ctr_init = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_mode = 1'b0;
    logic [127:0]  in_data = '0;
    logic [127:0]  in_key = '0;
    logic [TW-1:0] in_tag = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [127:0]  out_data;
    logic [TW-1:0] out_tag;

    aes_128_stream #(.CORE_LATENCY(L), .TAG_W(TW), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .ctr_load(ctr_load), .ctr_init(ctr_init),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .in_data(in_data), .in_key(in_key), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference AES (byte arrays, generated S-box) -------
    logic [7:0] sbox [256];

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
        logic [31:0] w [44];
        logic [7:0]  s [16];
        logic [7:0]  t [16];
        logic [7:0]  coef [4];
        logic [7:0]  rc;
        logic [31:0] tmp;
        logic [127:0] res;
        coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]], sbox[tmp[31:24]]} ^ {rc, 24'h0};
                rc  = gm(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) s[4*c+r] = t[4*((c+r)%4)+r];
            if (rnd < 10) begin
                for (int i = 0; i < 16; i++) t[i] = s[i];
                for (int c = 0; c < 4; c++)
                    for (int r = 0; r < 4; r++) begin
                        s[4*c+r] = 8'h00;
                        for (int k = 0; k < 4; k++)
                            s[4*c+r] = s[4*c+r] ^ gm(coef[(k-r+4)%4], t[4*c+k]);
                    end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rnd+i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    function automatic logic [127:0] ctr_next(input logic [127:0] c);
        logic [31:0] lo;
        lo = c[31:0] + 32'd1;
        return {c[127:32], lo};
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- scoreboard / single compare process ----------------
    typedef struct {
        logic [127:0]  data;
        logic [TW-1:0] tag;
        int unsigned   due;
    } exp_t;

    exp_t         q[$];
    exp_t         e;
    logic [127:0] m_ctr = '0;
    int unsigned  cyc = 0;
    logic         exp_ready, exp_valid;

    always @(negedge clk) begin
        #1;
        if (rst) begin
            chk("rst_in_ready", in_ready, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_data", out_data, 0);
            chk("rst_out_tag", out_tag, 0);
            q.delete();
            m_ctr = '0;
        end else begin
            exp_ready = !ctr_load && (q.size() < D);
            exp_valid = (q.size() > 0) && (q[0].due <= cyc);
            chk("in_ready", in_ready, exp_ready);
            chk("out_valid", out_valid, exp_valid);
            if (exp_valid) begin
                chk("out_data", out_data, q[0].data);
                chk("out_tag", out_tag, q[0].tag);
                if (out_ready) void'(q.pop_front());
            end
            if (ctr_load) begin
                m_ctr = ctr_init;
            end else if (in_valid && exp_ready) begin
                e.data = in_mode ? (aes_enc(in_key, m_ctr) ^ in_data) : aes_enc(in_key, in_data);
                e.tag  = in_tag;
                e.due  = cyc + L + 1;
                q.push_back(e);
                if (in_mode) m_ctr = ctr_next(m_ctr);
            end
        end
        cyc++;
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic v, input logic m, input logic [127:0] d,
                         input logic [127:0] k, input logic [TW-1:0] t);
        @(negedge clk);
        ctr_load = 1'b0;
        in_valid = v;
        in_mode  = m;
        in_data  = d;
        in_key   = k;
        in_tag   = t;
    endtask

    task automatic load_ctr(input logic [127:0] v);
        @(negedge clk);
        ctr_load = 1'b1;
        ctr_init = v;
        in_valid = 1'b1;          // must not be accepted
        in_mode  = 1'b0;
        in_data  = rnd128();
    endtask

    task automatic wait_drain(input int limit);
        int n = 0;
        while (q.size() != 0 && n < limit) begin
            drive(1'b0, 1'b0, '0, '0, '0);
            n++;
        end
        if (q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: %0d beats pending, required 0", q.size());
        end
    endtask

    logic [127:0] keys [3];

    initial begin
        logic [7:0] p, qq, x;
        // S-box from the generator walk over GF(2^8)
        p = 8'h01; qq = 8'h01;
        do begin
            p  = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            qq = qq ^ {qq[6:0], 1'b0};
            qq = qq ^ {qq[5:0], 2'b0};
            qq = qq ^ {qq[3:0], 4'b0};
            if (qq[7]) qq = qq ^ 8'h09;
            x = qq ^ {qq[6:0], qq[7]} ^ {qq[5:0], qq[7:6]} ^ {qq[4:0], qq[7:5]} ^ {qq[3:0], qq[7:4]};
            sbox[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox[0] = 8'h63;

        // Pin the model to known answers
        chk("pin_fips_a", aes_enc(FIPS_KEY_A, FIPS_PT_A), FIPS_CT_A);
        chk("pin_fips_b", aes_enc(FIPS_KEY_B, FIPS_PT_B), FIPS_CT_B);
        chk("pin_ctr1", aes_enc(SP_CTR_KEY, SP_CTR_INIT) ^ SP_CTR_PT1, SP_CTR_CT1);
        chk("pin_ctr2", aes_enc(SP_CTR_KEY, 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00) ^ SP_CTR_PT2, SP_CTR_CT2);
        chk("pin_wrap", ctr_next(128'h0123456789abcdef01234567ffffffff),
            128'h0123456789abcdef0123456700000000);

        keys[0] = FIPS_KEY_A; keys[1] = FIPS_KEY_B; keys[2] = rnd128();

        repeat (3) @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;

        // ECB known answers, each into an empty FIFO
        drive(1'b1, 1'b0, FIPS_PT_A, FIPS_KEY_A, 4'h5);
        wait_drain(60);
        drive(1'b1, 1'b0, FIPS_PT_B, FIPS_KEY_B, 4'ha);
        wait_drain(60);

        // CTR known answers
        load_ctr(SP_CTR_INIT);
        drive(1'b1, 1'b1, SP_CTR_PT1, SP_CTR_KEY, 4'h1);
        drive(1'b1, 1'b1, SP_CTR_PT2, SP_CTR_KEY, 4'h2);
        wait_drain(60);

        // Counter wrap, zero and non-zero upper bits, ECB interleaved
        load_ctr(128'h000000000000000000000000ffffffff);
        drive(1'b1, 1'b1, '0, FIPS_KEY_B, 4'h3);
        drive(1'b1, 1'b1, '0, FIPS_KEY_B, 4'h4);
        load_ctr(128'hdeadbeef0011223344556677fffffffe);
        drive(1'b1, 1'b1, rnd128(), keys[2], 4'h6);
        drive(1'b1, 1'b0, rnd128(), keys[2], 4'h7);
        drive(1'b1, 1'b1, rnd128(), keys[2], 4'h8);
        drive(1'b1, 1'b1, rnd128(), keys[2], 4'h9);
        wait_drain(60);

        // Backpressure: 40 back-to-back beats, only DEPTH may enter
        out_ready = 1'b0;
        for (int i = 0; i < 40; i++) drive(1'b1, 1'b0, rnd128(), keys[i % 3], TW'(i));
        drive(1'b0, 1'b0, '0, '0, '0);
        out_ready = 1'b1;
        wait_drain(120);

        // Randomized mixed traffic
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            ctr_load  = ($urandom_range(24) == 0);
            ctr_init  = rnd128();
            in_valid  = ($urandom_range(3) != 0);
            in_mode   = 1'($urandom_range(1));
            in_data   = rnd128();
            in_key    = keys[$urandom_range(2)];
            in_tag    = TW'($urandom_range(15));
            out_ready = ((i / 100) % 3 == 2) ? ($urandom_range(9) == 0) : ($urandom_range(9) < 7);
        end
        out_ready = 1'b1;
        wait_drain(200);

        // Reset mid-stream: FIFO partly filled and beats in flight
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, rnd128(), keys[1], TW'(i));
        for (int i = 0; i < 25; i++) drive(1'b0, 1'b0, '0, '0, '0);
        for (int i = 0; i < 10; i++) drive(1'b1, 1'b1, rnd128(), keys[0], TW'(i));
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, 1'b1, rnd128(), keys[2], 4'hc);
        drive(1'b1, 1'b0, rnd128(), keys[2], 4'hd);
        wait_drain(60);
        for (int i = 0; i < 40; i++) drive(1'b0, 1'b0, '0, '0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete, required finish");
        $fatal(1);
    end

endmodule

// File: doc/aes_128_stream.md
# aes_128_stream

Streaming wrapper around the team's fixed-latency pipelined `aes_128` core. It adds a valid/ready handshake on both sides, per-beat tags, and a per-beat ECB/CTR mode with an internal 32-bit-increment counter. A credit-managed output FIFO gives the non-stallable core pipeline downstream backpressure. It sits between the host bus bridge and the crypto datapath, replacing direct free-running use of the core.

## Interface
- `CORE_LATENCY`, 20: cycles from core `state`/`key` input to valid core `out`; must match the instantiated core.
- `TAG_W`, 4: width of the per-beat sideband tag.
- `DEPTH`, 32: output FIFO entries, power of two, ≥ 2. Full throughput requires `DEPTH ≥ CORE_LATENCY+2`.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `ctr_load` in 1: load `ctr_init` into the counter this cycle.
- `ctr_init` in 128: initial counter block.
- `in_valid` in 1, `in_ready` out 1: input handshake.
- `in_mode` in 1: 0 = ECB, 1 = CTR.
- `in_data` in 128: plaintext (ECB: block to encrypt; CTR: block XORed with keystream).
- `in_key` in 128: per-beat key.
- `in_tag` in TAG_W: returned unchanged with the result.
- `out_valid` out 1, `out_ready` in 1: output handshake.
- `out_data` out 128: ciphertext.
- `out_tag` out TAG_W: tag of this result.

## Operation
- Accept occurs when `in_valid && in_ready`. Core input: ECB → `in_data`; CTR → `ctr` register.
- Sideband delay line, `CORE_LATENCY` stages, carries {valid, mode, tag, data if CTR}. It is reset-cleared; the core datapath itself is not reset.
- At the delay-line tail with valid=1, FIFO write is: ECB → `core_out`; CTR → `core_out ^ data`, together with the tag.
- Counter:
  - On a CTR accept, `ctr[31:0] <= ctr[31:0]+1` (mod 2^32); `ctr[127:32]` is unchanged.
  - ECB beats do not touch `ctr`.
  - `ctr_load` forces `in_ready=0` that cycle and has priority, so no accept and no increment occur.
- Credits:
  - `credit` counts in-flight plus FIFO-resident beats, range 0..DEPTH.
  - +1 on accept, −1 on output handshake; both in the same cycle means net 0.
  - `in_ready = !rst && !ctr_load && credit < DEPTH`. The FIFO can therefore never overflow; a write into a full FIFO is an assertion failure.
- Output: `out_valid = !fifo_empty`, with data and tag taken from the FIFO head. They must be held stable while `out_valid && !out_ready`.
- Ordering: strictly in-order. ECB and CTR beats may interleave freely.
- Reset (async, including mid-stream):
  - `ctr=0`, `credit=0`, delay-line valids cleared, FIFO emptied.
  - `out_valid=0`, `out_data=0`, `out_tag=0`, `in_ready=0` while `rst` is high.
  - In-flight beats are dropped; no partial output survives.

## Timing
- Latency: beat accepted in cycle t → written into the FIFO at the edge ending cycle t+CORE_LATENCY → `out_valid` in cycle t+CORE_LATENCY+1 if the FIFO was empty. The FIFO has no fall-through.
- Throughput is one beat per cycle when `out_ready` is held 1 and `DEPTH ≥ CORE_LATENCY+2`.
- `in_ready` is registered-credit based, with no combinational path from `out_ready`.
- The first cycle after reset deasserts has `in_ready=1` if `ctr_load=0`.

## Structure
- Shared package `aes_pkg`:
  - `AES_BLK_W=128`
  - mode enum `aes_mode_e {AES_ECB=0, AES_CTR=1}`
  - FIPS-197 and SP800-38A test-vector constants for benches.
- Sub-module `aes_stream_fifo`: synchronous FIFO, parametrised width and depth, async active-high reset, pointer-based full/empty.
- Top level contains the `aes_128` instance, delay line, counter, credit logic and XOR.

## Test plan
- ECB, FIPS-197 vectors:
  - key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff → 69c4e0d86a7b0430d8cdb78070b4c55a.
  - key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 → 3925841d02dc09fbdc118597196a0b32.
  - Both must show `out_valid` exactly CORE_LATENCY+1 cycles after accept, with tags preserved.
- CTR (SP800-38A F.5.1), `ctr_init` f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, key 2b7e1516…4f3c:
  - pt 6bc1bee22e409f96e93d7e117393172a → 874d6191b620e3261bef6864990db6ce.
  - pt ae2d8a571e03ac9c9eb76fac45af8e51 → 9806f66b7970fdff8617187bb9fffdff.
- Counter wrap: `ctr_init` = 0…0_ffffffff, two CTR beats → the core sees …ffffffff then 0…0_00000000, upper 96 bits unchanged.
- Backpressure: `out_ready=0`, 40 back-to-back ECB beats → exactly DEPTH accepted, `in_ready` low at `credit=DEPTH`, no overflow. Then release `out_ready` → all DEPTH beats drain in order, tags 0..DEPTH−1 mod 2^TAG_W.
- Mixed modes with random `in_valid`/`out_ready` against a reference model: ECB beats leave `ctr` unchanged, and a `ctr_load` cycle accepts nothing.
- Reset asserted with 10 beats in flight → outputs zero immediately (async). After release, no stale beat ever appears and the next accepted beat behaves as after power-up.
